prefetch_ctrl: RTL and testbench

Sequencing controller for the instruction prefetch path. Issues in-order fetch requests to instruction memory, tracks outstanding requests against free slots in an internal DEPTH-entry {pc, instr} FIFO, and presents fetched instructions to decode through a valid/ready handshake. On a redirect (branch/jump/trap) it flushes buffered and in-flight instructions and restarts fetching at the new PC.

---
 rtl/prefetch_pkg.sv | 16 +
 rtl/prefetch_fifo.sv | 57 +++++
 rtl/prefetch_ctrl.sv | 125 ++++++++++++
 tb/tb_prefetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch path.
package prefetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [1:0] PF_IDLE  = 2'd0;
  localparam logic [1:0] PF_RUN   = 2'd1;
  localparam logic [1:0] PF_DRAIN = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} entries with push/pop/clear and occupancy count.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  pf_entry_t                    push_data,
  input  logic                         pop,
  input  logic                         clear,
  output pf_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  pf_entry_t     mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, rd_ptr_q, count_q;
  logic          do_push, do_pop;

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch sequencer: credit-limited in-order fetch, FIFO to decode, flush/redirect.
// Optional PREFETCH_CTRL_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module prefetch_ctrl
  import prefetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               flush_valid,
  input  logic [ADDR_W-1:0]  flush_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push, fifo_pop, fifo_clear, fifo_empty;
  logic              rsp_hit, rsp_take, has_credit;
  logic [ADDR_W-1:0] rsp_addr;
  pf_entry_t         fifo_head, rsp_entry;

  assign fifo_empty = (fifo_count == '0);
  assign rsp_hit    = imem_rsp_valid && (outstanding_q != '0);
  // Responses return in order, so the oldest outstanding request trails pc by outstanding words.
  assign rsp_addr   = pc_q - (ADDR_W'(outstanding_q) << 2);
  assign rsp_entry  = '{pc: rsp_addr, instr: imem_rsp_data};
  assign has_credit = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);
  assign imem_req_addr = pc_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    outstanding_d  = outstanding_q;
    discard_d      = discard_q;
    imem_req_valid = 1'b0;
    rsp_take       = 1'b0;
    fifo_clear     = 1'b0;
    case (state_q)
      PF_IDLE: state_d = PF_RUN;
      PF_RUN, PF_DRAIN: begin
        if (flush_valid) begin
          // Everything still in flight, minus a response landing now, must be dropped.
          fifo_clear    = 1'b1;
          pc_d          = {flush_pc[ADDR_W-1:2], 2'b00};
          outstanding_d = outstanding_q - CW'(rsp_hit);
          discard_d     = outstanding_d;
          state_d       = (outstanding_d != '0) ? PF_DRAIN : PF_RUN;
        end else if (state_q == PF_RUN) begin
          imem_req_valid = has_credit;
          rsp_take       = rsp_hit;
          outstanding_d  = outstanding_q + CW'(imem_req_valid && imem_req_ready) - CW'(rsp_hit);
          if (imem_req_valid && imem_req_ready) begin
            pc_d = pc_q + 32'd4;
          end
        end else if (rsp_hit) begin
          discard_d     = discard_q - 1'b1;
          outstanding_d = outstanding_q - 1'b1;
          if (discard_q == CW'(1)) begin
            state_d = PF_RUN;
          end
        end
      end
      default: state_d = PF_IDLE;
    endcase
  end

  always_comb begin
    dec_valid = !fifo_empty && !flush_valid;
    dec_instr = fifo_head.instr;
    dec_pc    = fifo_head.pc;
    fifo_pop  = dec_valid && dec_ready;
    fifo_push = rsp_take;
`ifdef PREFETCH_CTRL_BYPASS_EN
    if (fifo_empty && rsp_take) begin
      dec_valid = 1'b1;
      dec_instr = imem_rsp_data;
      dec_pc    = rsp_addr;
      fifo_pop  = 1'b0;
      fifo_push = !dec_ready;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= PF_IDLE;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(rsp_entry),
    .pop      (fifo_pop),
    .clear    (fifo_clear),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Bench for prefetch_ctrl: directed scenarios plus randomized traffic against a stream-level model.
module tb_prefetch_ctrl;
  import prefetch_pkg::*;

  localparam int unsigned DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_CTRL_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;

  prefetch_ctrl #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .flush_valid   (flush_valid),
    .flush_pc      (flush_pc),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_ready     (dec_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_t;

  mem_t        mq[$];
  int          errors = 0, checks = 0, cyc = 0;
  int          rdy_pct = 100, dec_pct = 100, lat_lo = 1, lat_hi = 1;
  bit          flush_now = 0, spurious = 0;
  logic [31:0] flush_tgt = '0;
  logic        s_req_valid, s_dec_valid, s_rsp;
  logic [31:0] s_req_addr;
  logic [31:0] exp_req, exp_dec;
  int          epoch = 0, iss_ep = 0, dec_ep = 0, dec_total = 0;

  // Instruction word depends on address and redirect epoch so stale data is recognisable.
  function automatic logic [31:0] instr_of(input logic [31:0] a, input int ep);
    return {a[15:0], a[31:16]} ^ (32'(ep) * 32'h0100_0193) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    flush_valid    = 1'b0;
    flush_now      = 0;
    spurious       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    flush_pc       = '0;
    #2;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk32("rst_req_addr", imem_req_addr, RESET_PC);
    chk1("rst_dec_valid", dec_valid, 1'b0);
    chk32("rst_dec_instr", dec_instr, 32'h0);
    chk32("rst_dec_pc", dec_pc, 32'h0);
    mq.delete();
    exp_req = RESET_PC;
    exp_dec = RESET_PC;
    epoch++;
    iss_ep  = 0;
    dec_ep  = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  // One clock cycle: drive memory/decode/flush, sample at negedge, update the model.
  task automatic cycle();
    if (spurious) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    dec_ready      = ($urandom_range(99) < dec_pct);
    flush_valid    = flush_now;
    flush_pc       = flush_tgt;
    @(negedge clock);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_dec_valid = dec_valid;
    s_rsp       = imem_rsp_valid;
    if (flush_valid) begin
      chk1("flush_masks_req", imem_req_valid, 1'b0);
      chk1("flush_masks_dec", dec_valid, 1'b0);
    end
    if (imem_rsp_valid && !spurious) void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      chk32("req_addr", imem_req_addr, exp_req);
      mq.push_back('{data: instr_of(imem_req_addr, epoch),
                     due: cyc + int'($urandom_range(lat_hi, lat_lo))});
      exp_req += 32'd4;
      iss_ep++;
    end
    if (dec_valid && dec_ready) begin
      chk32("dec_pc", dec_pc, exp_dec);
      chk32("dec_instr", dec_instr, instr_of(exp_dec, epoch));
      exp_dec += 32'd4;
      dec_ep++;
      dec_total++;
    end
    chk1("credit_bound", (iss_ep - dec_ep) <= int'(DEPTH), 1'b1);
    if (flush_valid) begin
      epoch++;
      exp_req = {flush_pc[31:2], 2'b00};
      exp_dec = exp_req;
      iss_ep  = 0;
      dec_ep  = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
    flush_now = 0;
    spurious  = 0;
  endtask

  initial begin
    int n;
    bit last_flush;
    #1;
    // Streaming from reset, latency 1, decode always ready.
    apply_reset();
    rdy_pct = 100; dec_pct = 100; lat_lo = 1; lat_hi = 1;
    cycle();
    chk1("idle_no_req", s_req_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("seq_req_valid", s_req_valid, 1'b1);
      chk32("seq_req_addr", s_req_addr, 32'(4 * i));
      if (i == 1) chk1("fetch_to_dec_latency", s_dec_valid, BYP);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk1("stream_no_gap", s_dec_valid, 1'b1);
    end

    // Decode stalled: credits stop issue at DEPTH, one pop frees one request.
    apply_reset();
    dec_pct = 0;
    cycle();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n += int'(s_req_valid);
    end
    chk32("credit_fill_reqs", 32'(n), 32'(DEPTH));
    chk1("credit_stall", s_req_valid, 1'b0);
    dec_pct = 100;
    cycle();
    chk1("single_pop", s_dec_valid, 1'b1);
    dec_pct = 0;
    n = int'(s_req_valid);
    for (int i = 0; i < 5; i++) begin
      cycle();
      n += int'(s_req_valid);
    end
    chk32("one_more_req", 32'(n), 32'd1);

    // Flush to 0x103 with two outstanding at latency 3.
    apply_reset();
    dec_pct = 100; lat_lo = 3; lat_hi = 3;
    cycle();
    cycle();
    cycle();
    flush_now = 1; flush_tgt = 32'h0000_0103;
    cycle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk1("drain_no_req", s_req_valid, 1'b0);
      chk1("drain_rsp_seen", s_rsp, 1'b1);
      chk1("drain_no_dec", s_dec_valid, 1'b0);
    end
    cycle();
    chk1("resume_req_valid", s_req_valid, 1'b1);
    chk32("resume_req_addr", s_req_addr, 32'h0000_0100);

    // Flush coincident with a response and a ready decode, redirecting to the wrap point.
    dec_pct = 0; lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 4; i++) cycle();
    lat_lo = 1; lat_hi = 1; dec_pct = 100;
    flush_now = 1; flush_tgt = 32'hFFFF_FFFC;
    cycle();
    chk1("coinc_rsp_present", s_rsp, 1'b1);
    chk1("coinc_dec_masked", s_dec_valid, 1'b0);
    cycle();
    chk1("coinc_fifo_cleared", s_dec_valid, 1'b0);
    chk1("wrap_req0_valid", s_req_valid, 1'b1);
    chk32("wrap_req0_addr", s_req_addr, 32'hFFFF_FFFC);
    cycle();
    chk1("wrap_req1_valid", s_req_valid, 1'b1);
    chk32("wrap_req1_addr", s_req_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) cycle();

    // Response with nothing outstanding is ignored.
    apply_reset();
    rdy_pct = 0; dec_pct = 100;
    cycle();
    spurious = 1;
    cycle();
    chk1("spurious_no_bypass", s_dec_valid, 1'b0);
    cycle();
    chk1("spurious_not_pushed", s_dec_valid, 1'b0);
    rdy_pct = 100;
    for (int i = 0; i < 5; i++) cycle();

    // Randomized traffic against the stream model.
    apply_reset();
    rdy_pct = 70; dec_pct = 60; lat_lo = 1; lat_hi = 5;
    dec_total = 0;
    last_flush = 0;
    cycle();
    for (int i = 0; i < 3000; i++) begin
      if (!last_flush && $urandom_range(99) < 3) begin
        flush_now = 1;
        flush_tgt = $urandom;
      end else if (mq.size() == 0 && $urandom_range(99) < 5) begin
        spurious = 1;
      end
      last_flush = flush_now;
      cycle();
    end
    chk1("random_liveness", dec_total > 300, 1'b1);
    rdy_pct = 100; dec_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20; i++) cycle();
    chk1("final_stream", s_dec_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
